reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Round-robin arbiter and sequencer for the shared 4-bit register bus (address, data, valid, ack, plus read-back data and read-back valid). The bus feeds the clock handler, UART, channel processor and color processor register banks. It lets several masters share that bus one transaction at a time: the UART address decoder, and a local configuration source such as a button/switch-driven preset loader. The arbiter guarantees that `bus_valid` is held until acked and returns low between transactions. It bounds each transaction with a timeout and routes read-back data to the granted master.

## Interface
Parameters:
- `N_REQ`, 2: number of masters, 2..4.
- `ADDR_W`, 4: bus address width.
- `DATA_W`, 4: bus data width.
- `TIMEOUT`, 255: maximum cycles `bus_valid` may wait for `bus_ack`, 1..255.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-master request; must be held until the matching `done`.
- `req_addr`  in  N_REQ*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- `req_data`  in  N_REQ*DATA_W  packed write data.
- `gnt`  out  N_REQ  one-hot grant, high for the whole transaction.
- `done`  out  N_REQ  one-cycle completion pulse to the granted master.
- `err`  out  1  one-cycle pulse coincident with `done` when the transaction timed out.
- `rd_data`  out  DATA_W  last read-back value captured.
- `rd_valid`  out  1  one-cycle pulse with `done` if read-back data was captured during the transaction.
- `bus_addr`  out  ADDR_W  registered bus address.
- `bus_data`  out  DATA_W  registered bus data.
- `bus_valid`  out  1  registered transaction strobe.
- `bus_ack`  in  1  OR of slave acks.
- `bus_rdata`  in  DATA_W  OR of slave read-back data.
- `bus_rdata_valid`  in  1  OR of slave read-back valids.

## Operation
States: IDLE, BUSY, RELEASE.
- IDLE
  - If `req` is nonzero, the arbiter selects the first set request searching upward (with wrap) from `ptr+1`.
  - It latches that master's address/data into `bus_addr`/`bus_data`, sets `gnt` one-hot, sets `bus_valid`, clears the timeout counter and goes to BUSY.
  - If `req` is zero, it stays in IDLE.
- BUSY
  - `bus_valid`=1, and `bus_addr`/`bus_data` are frozen.
  - The timeout counter increments each cycle.
  - On `bus_rdata_valid`=1, `rd_data` takes `bus_rdata` and an internal captured flag is set.
  - On `bus_ack`=1, or when the counter reaches TIMEOUT, the arbiter goes to RELEASE. It sets `err` only if the exit was by timeout without ack; ack wins if both occur in the same cycle.
- RELEASE
  - `bus_valid`=0, `gnt`=0.
  - `done`[winner]=1, `err`/`rd_valid` per the BUSY outcome.
  - `ptr` takes the winner index; next state is IDLE.
- Requests are not preempted. Deasserting `req` during BUSY does not abort the transaction, and `done` is still issued.
- A master that keeps `req` high after `done` re-enters arbitration. Round-robin then favours any other pending master.
- `rd_data` holds its value between captures. If several `bus_rdata_valid` pulses occur in one transaction, the last one wins.

## Timing
- Reset (`rst`=0, asynchronous):
  - state IDLE.
  - `gnt`, `done`, `err`, `rd_valid`, `bus_valid` = 0.
  - `bus_addr`, `bus_data`, `rd_data` = 0.
  - `ptr` = N_REQ-1, so master 0 has first priority.
- Reset asserted mid-transaction drops `bus_valid` immediately. No `done` is issued.
- Handshake cycles:
  - `req` is seen high in IDLE at edge k; `gnt` and `bus_valid` are high from edge k.
  - `bus_ack` is sampled high at edge m; `bus_valid` goes low, `done` pulses, and `gnt` drops from edge m.
  - The next grant comes no earlier than edge m+2. `bus_valid` is therefore low for at least 1 full cycle between transactions.
- Fastest transaction is 3 cycles from grant to the next possible grant.
- Timeout: with no ack, `bus_valid` is high for exactly TIMEOUT cycles.
- Counter width is 8 bits; it never wraps because it is cleared on every grant.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `reg_bus_pkg`:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2)
  - `ADDR_W`/`DATA_W` defaults
  - the `TIMEOUT` default
- Sub-module `rr_select`: combinational round-robin picker with inputs `req` and `ptr`, outputs one-hot winner, winner index and `any`. It is reusable for other shared resources.
- Top `reg_bus_arbiter`: FSM, timeout counter, bus registers, read-back capture.

## Test plan
- Single master: master0 requests addr 4'h3, data 4'hA; slave acks 2 cycles after `bus_valid` rises.
  - Required: `bus_addr`=3 and `bus_data`=A stable while `bus_valid`=1, `done`[0] one pulse, `err`=0.
- Contention: master0 and master1 request simultaneously and both stay asserted for 4 transactions.
  - Required: grants alternate 0,1,0,1.
  - Required: `bus_valid` low at least 1 cycle between transactions.
- Timeout: TIMEOUT=8 and the slave never acks.
  - Required: `bus_valid` high exactly 8 cycles, then `done`[i] and `err` pulse together.
  - Required: the next request is served normally.
- Ack on the timeout cycle: ack arrives at count TIMEOUT.
  - Required: `done` pulses with `err`=0.
- Read-back: slave asserts `bus_rdata_valid` with 4'h5 and then acks.
  - Required: `rd_data`=5 and `rd_valid` pulses with `done`.
  - Required: `rd_data` still holds 5 after a later write-only transaction, with `rd_valid`=0.
- Reset mid-BUSY: `rst` is asserted low while `bus_valid`=1.
  - Required: all outputs clear immediately and no `done` is issued.
  - Required: after release, master0 is granted first.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-bus arbiter.
package reg_bus_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W       = 8;
endpackage

// File: rtl/reg_bus_arbiter_rr_select.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_select #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        winner[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared register bus with ack timeout
// and read-back routing; all outputs registered.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_data,
  output logic                     bus_valid,
  input  logic                     bus_ack,
  input  logic [DATA_W-1:0]        bus_rdata,
  input  logic                     bus_rdata_valid
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n, win, win_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic               cap, cap_n, timeout_hit;
  logic [N_REQ-1:0]   gnt_n, done_n, sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               err_n, rd_valid_n, bus_valid_n;
  logic [DATA_W-1:0]  rd_data_n, bus_data_n;
  logic [ADDR_W-1:0]  bus_addr_n;

  rr_select #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_select (
    .req    (req),
    .ptr    (ptr),
    .winner (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  // Count value after this cycle; bus_valid has then been high cnt_inc cycles.
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    win_n       = win;
    cnt_n       = cnt;
    cap_n       = cap;
    gnt_n       = gnt;
    done_n      = '0;
    err_n       = 1'b0;
    rd_valid_n  = 1'b0;
    rd_data_n   = rd_data;
    bus_addr_n  = bus_addr;
    bus_data_n  = bus_data;
    bus_valid_n = bus_valid;
    case (state)
      IDLE: begin
        if (sel_any) begin
          state_n     = BUSY;
          win_n       = sel_idx;
          gnt_n       = sel_onehot;
          bus_addr_n  = req_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
          bus_data_n  = req_data[32'(sel_idx)*DATA_W +: DATA_W];
          bus_valid_n = 1'b1;
          cnt_n       = '0;
          cap_n       = 1'b0;
        end
      end
      BUSY: begin
        cnt_n = cnt_inc;
        if (bus_rdata_valid) begin
          rd_data_n = bus_rdata;
          cap_n     = 1'b1;
        end
        if (bus_ack || timeout_hit) begin
          state_n     = RELEASE;
          bus_valid_n = 1'b0;
          gnt_n       = '0;
          done_n      = gnt;
          err_n       = !bus_ack;
          rd_valid_n  = cap | bus_rdata_valid;
        end
      end
      RELEASE: begin
        ptr_n   = win;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N_REQ - 1);
      win       <= '0;
      cnt       <= '0;
      cap       <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      bus_addr  <= '0;
      bus_data  <= '0;
      bus_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      win       <= win_n;
      cnt       <= cnt_n;
      cap       <= cap_n;
      gnt       <= gnt_n;
      done      <= done_n;
      err       <= err_n;
      rd_valid  <= rd_valid_n;
      rd_data   <= rd_data_n;
      bus_addr  <= bus_addr_n;
      bus_data  <= bus_data_n;
      bus_valid <= bus_valid_n;
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed table, reset corner case,
// then randomized transactions against a transaction-level model.
module tb_reg_bus_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned T  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt, done;
  logic            err, rd_valid, bus_valid;
  logic [DW-1:0]   rd_data, bus_data, bus_rdata;
  logic [AW-1:0]   bus_addr;
  logic            bus_ack, bus_rdata_valid;

  reg_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .gnt             (gnt),
    .done            (done),
    .err             (err),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .bus_addr        (bus_addr),
    .bus_data        (bus_data),
    .bus_valid       (bus_valid),
    .bus_ack         (bus_ack),
    .bus_rdata       (bus_rdata),
    .bus_rdata_valid (bus_rdata_valid)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int unsigned   lw;          // last served master
  logic [DW-1:0] rd_model;
  bit            after_txn;

  typedef struct {
    logic [N-1:0]    r;
    logic [N*AW-1:0] ap;
    logic [N*DW-1:0] dp;
    int unsigned     ack_at;
    int unsigned     rv_at;
    logic [DW-1:0]   rv_val;
    int unsigned     rv2_at;
    logic [DW-1:0]   rv2_val;
    logic [N-1:0]    g;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned last);
    for (int unsigned k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return N;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_at: cycle after grant whose edge samples ack (0 = never).
  task automatic run_txn(input string tag, input logic [N-1:0] r,
                         input logic [N*AW-1:0] ap, input logic [N*DW-1:0] dp,
                         input int unsigned ack_at, input int unsigned rv_at,
                         input logic [DW-1:0] rv_val, input int unsigned rv2_at,
                         input logic [DW-1:0] rv2_val, input logic [N-1:0] exp_gnt);
    int unsigned wi, j, exp_len, waited;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit stable, rdv_exp, exp_err;
    wi = 0;
    for (int unsigned k = 0; k < N; k++) if (exp_gnt[k]) wi = k;
    ea = ap[wi*AW +: AW];
    ed = dp[wi*DW +: DW];
    exp_err = (ack_at == 0) || (ack_at > T);
    exp_len = exp_err ? T : ack_at;
    req = r; req_addr = ap; req_data = dp;
    bus_ack = 1'b0; bus_rdata_valid = 1'b0;
    waited = 0;
    while (gnt == '0 && waited < 6) begin
      step();
      waited++;
    end
    chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    if (after_txn) chk({tag, " grant latency"}, waited, 1);
    if (gnt == '0) return;
    chk({tag, " bus_valid at grant"}, 32'(bus_valid), 1);
    chk({tag, " bus_addr"}, 32'(bus_addr), 32'(ea));
    chk({tag, " bus_data"}, 32'(bus_data), 32'(ed));
    j = 0; stable = 1; rdv_exp = 0;
    while (bus_valid && j < T + 4) begin
      j++;
      bus_ack = (j == ack_at);
      bus_rdata_valid = (j == rv_at) || (j == rv2_at);
      bus_rdata = bus_rdata_valid ? ((j == rv2_at) ? rv2_val : rv_val) : DW'($urandom);
      if (bus_rdata_valid) begin
        rd_model = bus_rdata;
        rdv_exp  = 1;
      end
      step();
      if (bus_valid && (bus_addr !== ea || bus_data !== ed || gnt !== exp_gnt || done !== '0))
        stable = 0;
    end
    bus_ack = 1'b0; bus_rdata_valid = 1'b0;
    chk({tag, " valid length"}, j, exp_len);
    chk({tag, " stable while valid"}, 32'(stable), 1);
    chk({tag, " done"}, 32'(done), 32'(exp_gnt));
    chk({tag, " gnt dropped"}, 32'(gnt), 0);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(rdv_exp));
    chk({tag, " rd_data"}, 32'(rd_data), 32'(rd_model));
    step();
    chk({tag, " gap/pulse end"}, {28'd0, |done, err, rd_valid, bus_valid}, 0);
    lw = wi;
    after_txn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned w;
    logic [N-1:0] r;
    rst = 1'b0; req = '0; req_addr = '0; req_data = '0;
    bus_ack = 1'b0; bus_rdata = '0; bus_rdata_valid = 1'b0;
    lw = N - 1; rd_model = '0; after_txn = 0;

    tbl[0]  = '{3'b001, 12'h003, 12'h00A, 2, 0, 4'h0, 0, 4'h0, 3'b001};
    tbl[1]  = '{3'b011, 12'h021, 12'h0B5, 1, 0, 4'h0, 0, 4'h0, 3'b010};
    tbl[2]  = '{3'b011, 12'h021, 12'h0B5, 1, 0, 4'h0, 0, 4'h0, 3'b001};
    tbl[3]  = '{3'b011, 12'h021, 12'h0B5, 1, 0, 4'h0, 0, 4'h0, 3'b010};
    tbl[4]  = '{3'b011, 12'h021, 12'h0B5, 1, 0, 4'h0, 0, 4'h0, 3'b001};
    tbl[5]  = '{3'b100, 12'h700, 12'hC00, 0, 0, 4'h0, 0, 4'h0, 3'b100};
    tbl[6]  = '{3'b100, 12'hE00, 12'h100, 3, 0, 4'h0, 0, 4'h0, 3'b100};
    tbl[7]  = '{3'b010, 12'h0D0, 12'h060, 8, 0, 4'h0, 0, 4'h0, 3'b010};
    tbl[8]  = '{3'b001, 12'h009, 12'h004, 2, 1, 4'h5, 0, 4'h0, 3'b001};
    tbl[9]  = '{3'b010, 12'h0F0, 12'h020, 1, 0, 4'h0, 0, 4'h0, 3'b010};
    tbl[10] = '{3'b001, 12'h00C, 12'h003, 3, 1, 4'h6, 3, 4'h9, 3'b001};

    #12;
    chk("reset outputs", {16'd0, gnt, done, err, rd_valid, bus_valid, bus_addr, bus_data},
        0);
    chk("reset rd_data", 32'(rd_data), 0);
    rst = 1'b1;

    for (int unsigned i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].ap, tbl[i].dp, tbl[i].ack_at,
              tbl[i].rv_at, tbl[i].rv_val, tbl[i].rv2_at, tbl[i].rv2_val, tbl[i].g);

    // Reset asserted mid-transaction
    req = 3'b010; req_addr = 12'h0A0; req_data = 12'h050;
    w = 0;
    while (gnt == '0 && w < 6) begin step(); w++; end
    chk("rst-mid gnt", 32'(gnt), 32'(3'b010));
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("rst-mid outputs clear", {16'd0, gnt, done, err, rd_valid, bus_valid, bus_addr, bus_data},
        0);
    chk("rst-mid rd_data clear", 32'(rd_data), 0);
    rd_model = '0;
    req = 3'b011; req_addr = 12'h042; req_data = 12'h087;
    step();
    chk("rst-mid no done", 32'(done), 0);
    step();
    #2 rst = 1'b1;
    lw = N - 1; after_txn = 0;
    run_txn("post-reset", 3'b011, 12'h042, 12'h087, 2, 0, 4'h0, 0, 4'h0, 3'b001);

    for (int unsigned i = 0; i < 40; i++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      run_txn($sformatf("rnd%0d", i), r, (N*AW)'($urandom), (N*DW)'($urandom),
              $urandom_range(0, T + 2), $urandom_range(0, T), DW'($urandom),
              $urandom_range(0, T), DW'($urandom), N'(1 << rr_pick(r, lw)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
